// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master.
package spi_pkg;

    // Transfer phases, in the order the master walks through them.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } spi_state_e;

    // SPI mode encodings: bit 1 is CPOL, bit 0 is CPHA.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Idle level of SCLK for a given mode.
    function automatic logic mode_cpol(input logic [1:0] m);
        return m[1];
    endfunction

    // Clock phase for a given mode: 0 samples on leading edges, 1 on trailing.
    function automatic logic mode_cpha(input logic [1:0] m);
        return m[0];
    endfunction

endpackage

// File: rtl/spi_tick_gen.sv
// Divides clk down to one-cycle ticks, one every CLK_DIV cycles while enabled.
module spi_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset_l,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A tick fires when the down-counter has run out.
    assign tick = enable && (cnt_q == '0);

    // Restart reloads so a new phase always gets a full tick; otherwise count down and wrap on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = RELOAD;
        end else if (enable) begin
            cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Single-word SPI master with selectable mode, chip select and bit order.
module spi_master
    import spi_pkg::*;
#(
    parameter int  DATA_W    = 16,
    parameter int  NUM_CS    = 4,
    parameter int  CLK_DIV   = 2,
    parameter int  MSB_FIRST = 1,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset_l,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic [NUM_CS-1:0] spi_cs_l,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    // SHIFT spends two ticks per bit; this counts those half-bit ticks.
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [EDGE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic              sclk_q, sclk_d;
    logic              mosi_q, mosi_d;
    logic [NUM_CS-1:0] cs_l_q, cs_l_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              tx_ready_q, tx_ready_d;
    logic              cpha_q, cpha_d;

    logic              tick;
    logic              tick_en;
    logic              restart;
    logic              accept;
    logic              leading;
    logic              sample_now;
    logic              advance;
    logic [DATA_W-1:0] tx_shifted;

    // Bit presented on MOSI for the word currently in the shifter.
    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return w[DATA_W-1];
        end
        return w[0];
    endfunction

    // Discard the bit just sent so the next one moves to the output end.
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        if (MSB_FIRST != 0) begin
            return {w[DATA_W-2:0], 1'b0};
        end
        return {1'b0, w[DATA_W-1:1]};
    endfunction

    // Append a received bit so the first bit received ends up in the first-sent position.
    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        if (MSB_FIRST != 0) begin
            return {w[DATA_W-2:0], b};
        end
        return {b, w[DATA_W-1:1]};
    endfunction

    // One-hot-low chip select; an out-of-range index leaves every line high.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] r;
        r = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    assign tick_en = (state_q != IDLE);
    assign accept  = tx_valid && tx_ready_q;

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_gen (
        .clk     (clk),
        .reset_l (reset_l),
        .restart (restart),
        .enable  (tick_en),
        .tick    (tick)
    );

    // Next-state logic: sequences the phases and decides sampling and MOSI updates on each tick.
    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        edge_cnt_d = edge_cnt_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_l_d     = cs_l_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        cpha_d     = cpha_q;
        restart    = 1'b0;
        tx_shifted = shift_out(tx_sr_q);
        leading    = ~edge_cnt_q[0];
        sample_now = leading ^ cpha_q;
        advance    = cpha_q ? (leading && (edge_cnt_q != '0))
                            : (!leading && (edge_cnt_q != EDGE_LAST));

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = SETUP;
                    tx_sr_d    = tx_data;
                    rx_sr_d    = '0;
                    edge_cnt_d = '0;
                    sclk_d     = mode_cpol(mode);
                    cpha_d     = mode_cpha(mode);
                    mosi_d     = first_bit(tx_data);
                    cs_l_d     = cs_decode(cs_sel);
                    restart    = 1'b1;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d    = SHIFT;
                    edge_cnt_d = '0;
                    restart    = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (sample_now) begin
                        rx_sr_d = shift_in(rx_sr_q, spi_miso);
                    end
                    if (advance) begin
                        tx_sr_d = tx_shifted;
                        mosi_d  = first_bit(tx_shifted);
                    end
                    if (edge_cnt_q == EDGE_LAST) begin
                        state_d = HOLD;
                        restart = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d    = GAP;
                    cs_l_d     = '1;
                    rx_data_d  = rx_sr_q;
                    rx_valid_d = 1'b1;
                    restart    = 1'b1;
                end
            end
            GAP: begin
                if (tick) begin
                    state_d = IDLE;
                    restart = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        tx_ready_d = (state_d == IDLE);
    end

    // State and registered bus outputs; reset drops chip selects immediately.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            edge_cnt_q <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_l_q     <= '1;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_ready_q <= 1'b0;
            cpha_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            edge_cnt_q <= edge_cnt_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_l_q     <= cs_l_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_ready_q <= tx_ready_d;
            cpha_q     <= cpha_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign busy     = (state_q != IDLE);
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign spi_cs_l = cs_l_q;
    assign spi_sclk = sclk_q;
    assign spi_mosi = mosi_q;

endmodule
